cpu_ctrl_seq: RTL

Eight-phase instruction sequencer for the 8-bit accumulator CPU. It drives the ALU's op_code consumer stage and the surrounding datapath: PC select, memory read/write, IR/AC/PC load strobes and halt. It consumes the 3-bit opcode from the instruction register and the ALU's a_is_zero flag. Each instruction takes exactly 8 clock cycles. The ALU result is captured by the accumulator on the ld_ac strobe from this block.

---
 rtl/cpu_ctrl_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: eight-phase instruction sequencer for the 8-bit accumulator CPU.
//
// Every instruction takes eight clock cycles (phases 0..7). The current phase is
// decoded together with the live opcode and zero inputs into datapath strobes.
// When phase 4 sees the halt opcode, the sequencer stops at phase 4 and stays
// halted until reset.
//
// Optional feature macro: CTRL_SINGLE_STEP_EN
//   When defined, an extra input `step` is added. The sequencer holds in phase 0
//   (after reset and after every phase 7) until it sees a cycle with step=1.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   step    in   single-step advance (only when CTRL_SINGLE_STEP_EN is defined)
//   opcode  in   [2:0] IR opcode field, valid from phase 4 onward
//   zero    in   ALU a_is_zero flag, used only in phase 6
//   phase   out  [2:0] current phase (this is the FSM state)
//   sel     out  1 = memory address from PC, 0 = from IR operand
//   rd      out  memory read enable
//   ld_ir   out  instruction register load strobe
//   inc_pc  out  PC increment strobe
//   ld_pc   out  PC load (jump) strobe
//   ld_ac   out  accumulator load strobe
//   wr      out  memory write strobe
//   data_e  out  accumulator drives the data bus
//   halt    out  halted indication (rises combinationally in phase 4)
module cpu_ctrl_seq #(
    parameter int         NUM_PHASES = 8,
    parameter logic [2:0] HLT_OP     = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);
    localparam logic [2:0] OP_SKZ     = 3'd1;
    localparam logic [2:0] OP_STO     = 3'd6;
    localparam logic [2:0] OP_JMP     = 3'd7;

    phase_t state, state_nxt;
    logic   halted, halted_nxt;
    logic   is_alu;
    logic   hlt_now;

    assign phase   = state;
    // ADD, AND, XOR and LDA all read an operand and load the accumulator.
    assign is_alu  = (opcode >= 3'd2) && (opcode <= 3'd5);
    assign hlt_now = (state == OP_ADDR) && (opcode == HLT_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        halted_nxt = halted;
        sel        = 1'b0;
        rd         = 1'b0;
        ld_ir      = 1'b0;
        inc_pc     = 1'b0;
        ld_pc      = 1'b0;
        ld_ac      = 1'b0;
        wr         = 1'b0;
        data_e     = 1'b0;
        halt       = 1'b1;

        if (!halted) begin
            halt = hlt_now;

            // Halting freezes the phase at OP_ADDR on the same edge the flag sets.
            if (hlt_now) begin
                halted_nxt = 1'b1;
            end else if (state == phase_t'(LAST_PHASE)) begin
                state_nxt = INST_ADDR;
`ifdef CTRL_SINGLE_STEP_EN
            end else if ((state == INST_ADDR) && !step) begin
                state_nxt = INST_ADDR;
`endif
            end else begin
                state_nxt = phase_t'(state + 3'd1);
            end

            case (state)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                end
                OP_FETCH: begin
                    rd = is_alu;
                end
                ALU_OP: begin
                    rd     = is_alu;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = is_alu;
                    ld_ac  = is_alu;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: ;
            endcase
        end
    end

endmodule
